// File: rtl/rob_pkg.sv
// Shared types, sizes and tag-arithmetic helpers for the reorder buffer.
package rob_pkg;

  localparam int unsigned ROB_WIDTH  = 4;
  localparam int unsigned PREG_WIDTH = 7;
  localparam int unsigned AREG_WIDTH = 5;
  localparam int unsigned ROB_DEPTH  = 2 ** ROB_WIDTH;

  typedef logic [ROB_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  reg_write;
    logic                  is_branch;
    logic [AREG_WIDTH-1:0] rd;
    logic [PREG_WIDTH-1:0] prd;
    logic [PREG_WIDTH-1:0] old_prd;
  } rob_entry_t;

  // Age of a tag relative to the head; wraps naturally with the tag width.
  function automatic rob_tag_t rob_age(input rob_tag_t tag, input rob_tag_t head);
    return tag - head;
  endfunction

  // Entries strictly younger than mtag and still inside the occupied window.
  function automatic logic [ROB_DEPTH-1:0] rob_age_mask(input rob_tag_t           head,
                                                        input rob_tag_t           mtag,
                                                        input logic [ROB_WIDTH:0] count);
    logic [ROB_DEPTH-1:0] mask;
    logic [ROB_WIDTH:0]   age_i;
    logic [ROB_WIDTH:0]   age_m;
    mask  = '0;
    age_m = {1'b0, rob_age(mtag, head)};
    for (int i = 0; i < int'(ROB_DEPTH); i++) begin
      age_i   = {1'b0, rob_age(ROB_WIDTH'(i), head)};
      mask[i] = (age_i > age_m) && (age_i < count);
    end
    return mask;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer: dispatch at tail, out-of-order
// completion, one in-order retire per cycle from head, squash on mispredict.
module reorder_buffer
  import rob_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  dispatch_valid,
  input  logic [ROB_WIDTH-1:0]  dispatch_rob_tag,
  input  logic [PREG_WIDTH-1:0] dispatch_prd,
  input  logic [PREG_WIDTH-1:0] dispatch_old_prd,
  input  logic [AREG_WIDTH-1:0] dispatch_rd,
  input  logic                  dispatch_reg_write,
  input  logic                  dispatch_is_branch,
  output logic                  rob_ready,
  input  logic                  wb_valid,
  input  logic [ROB_WIDTH-1:0]  wb_rob_tag,
  input  logic                  branch_mispredict,
  input  logic [ROB_WIDTH-1:0]  mispredict_rob_tag,
  output logic                  retire_valid,
  output logic [ROB_WIDTH-1:0]  retire_rob_tag,
  output logic                  commit_en,
  output logic [PREG_WIDTH-1:0] commit_old_preg,
  output logic [PREG_WIDTH-1:0] commit_prd,
  output logic [AREG_WIDTH-1:0] commit_rd,
  output logic                  rob_empty,
  output logic                  alloc_error
);

  localparam int unsigned CNT_W = ROB_WIDTH + 1;

  rob_entry_t           ent_q [ROB_DEPTH];
  rob_entry_t           ent_d [ROB_DEPTH];
  rob_tag_t             head_q, head_d;
  rob_tag_t             tail_q, tail_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 alloc_error_q, alloc_error_d;

  logic                 mp_ok;
  logic                 mp_bad;
  logic [ROB_DEPTH-1:0] squash;
  logic                 disp_req;
  logic                 disp_bad;
  logic                 disp_ok;
  logic                 wb_ok;

  // Retire view of the head entry; payload is zeroed when nothing retires.
  always_comb begin
    retire_valid    = ent_q[head_q].valid && ent_q[head_q].done && (count_q != '0);
    retire_rob_tag  = retire_valid ? head_q : '0;
    commit_en       = retire_valid && ent_q[head_q].reg_write;
    commit_old_preg = retire_valid ? ent_q[head_q].old_prd : '0;
    commit_prd      = retire_valid ? ent_q[head_q].prd : '0;
    commit_rd       = retire_valid ? ent_q[head_q].rd : '0;
    rob_empty       = (count_q == '0);
    rob_ready       = (count_q != CNT_W'(ROB_DEPTH));
    alloc_error     = alloc_error_q;
  end

  // Qualify dispatch, writeback and mispredict requests against current state.
  always_comb begin
    mp_ok    = branch_mispredict && ent_q[mispredict_rob_tag].valid;
    mp_bad   = branch_mispredict && !ent_q[mispredict_rob_tag].valid;
    squash   = mp_ok ? rob_age_mask(head_q, mispredict_rob_tag, count_q) : '0;
    disp_req = dispatch_valid && !branch_mispredict;
    disp_bad = disp_req && (!rob_ready || (dispatch_rob_tag != tail_q));
    disp_ok  = disp_req && !disp_bad;
    wb_ok    = wb_valid && ent_q[wb_rob_tag].valid && !squash[wb_rob_tag];
  end

  // Next-state for the entry array, pointers, occupancy and error flag.
  always_comb begin
    ent_d         = ent_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    alloc_error_d = alloc_error_q | disp_bad | mp_bad;

    if (wb_ok) begin
      ent_d[wb_rob_tag].done = 1'b1;
    end

    if (retire_valid) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + ROB_WIDTH'(1);
    end

    for (int i = 0; i < int'(ROB_DEPTH); i++) begin
      if (squash[i]) begin
        ent_d[i].valid = 1'b0;
        ent_d[i].done  = 1'b0;
      end
    end

    if (disp_ok) begin
      ent_d[tail_q] = '{valid:     1'b1,
                        done:      1'b0,
                        reg_write: dispatch_reg_write,
                        is_branch: dispatch_is_branch,
                        rd:        dispatch_rd,
                        prd:       dispatch_prd,
                        old_prd:   dispatch_old_prd};
      tail_d = tail_q + ROB_WIDTH'(1);
    end

    if (mp_ok) begin
      tail_d  = mispredict_rob_tag + ROB_WIDTH'(1);
      count_d = {1'b0, rob_age(mispredict_rob_tag, head_q)} + CNT_W'(1) - CNT_W'(retire_valid);
    end else begin
      count_d = count_q + CNT_W'(disp_ok) - CNT_W'(retire_valid);
    end
  end

  // State registers; reset drops every in-flight entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ROB_DEPTH); i++) begin
        ent_q[i] <= '0;
      end
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      alloc_error_q <= 1'b0;
    end else begin
      ent_q         <= ent_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      alloc_error_q <= alloc_error_d;
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer.
module tb_reorder_buffer;
  import rob_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  dispatch_valid;
  logic [ROB_WIDTH-1:0]  dispatch_rob_tag;
  logic [PREG_WIDTH-1:0] dispatch_prd;
  logic [PREG_WIDTH-1:0] dispatch_old_prd;
  logic [AREG_WIDTH-1:0] dispatch_rd;
  logic                  dispatch_reg_write;
  logic                  dispatch_is_branch;
  logic                  rob_ready;
  logic                  wb_valid;
  logic [ROB_WIDTH-1:0]  wb_rob_tag;
  logic                  branch_mispredict;
  logic [ROB_WIDTH-1:0]  mispredict_rob_tag;
  logic                  retire_valid;
  logic [ROB_WIDTH-1:0]  retire_rob_tag;
  logic                  commit_en;
  logic [PREG_WIDTH-1:0] commit_old_preg;
  logic [PREG_WIDTH-1:0] commit_prd;
  logic [AREG_WIDTH-1:0] commit_rd;
  logic                  rob_empty;
  logic                  alloc_error;

  int checks   = 0;
  int failures = 0;

  reorder_buffer dut (
    .clk                (clk),
    .reset              (reset),
    .dispatch_valid     (dispatch_valid),
    .dispatch_rob_tag   (dispatch_rob_tag),
    .dispatch_prd       (dispatch_prd),
    .dispatch_old_prd   (dispatch_old_prd),
    .dispatch_rd        (dispatch_rd),
    .dispatch_reg_write (dispatch_reg_write),
    .dispatch_is_branch (dispatch_is_branch),
    .rob_ready          (rob_ready),
    .wb_valid           (wb_valid),
    .wb_rob_tag         (wb_rob_tag),
    .branch_mispredict  (branch_mispredict),
    .mispredict_rob_tag (mispredict_rob_tag),
    .retire_valid       (retire_valid),
    .retire_rob_tag     (retire_rob_tag),
    .commit_en          (commit_en),
    .commit_old_preg    (commit_old_preg),
    .commit_prd         (commit_prd),
    .commit_rd          (commit_rd),
    .rob_empty          (rob_empty),
    .alloc_error        (alloc_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic disp(input int tag, input int prd, input int old, input int rd,
                      input int rw, input int br);
    dispatch_valid     = 1'b1;
    dispatch_rob_tag   = ROB_WIDTH'(tag);
    dispatch_prd       = PREG_WIDTH'(prd);
    dispatch_old_prd   = PREG_WIDTH'(old);
    dispatch_rd        = AREG_WIDTH'(rd);
    dispatch_reg_write = 1'(rw);
    dispatch_is_branch = 1'(br);
    tick();
    dispatch_valid     = 1'b0;
  endtask

  task automatic wb(input int tag);
    wb_valid   = 1'b1;
    wb_rob_tag = ROB_WIDTH'(tag);
    tick();
    wb_valid   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  task automatic chk_retire(input string tag, input int rv, input int t, input int old);
    chk({tag, "_valid"}, 32'(retire_valid), 32'(rv));
    chk({tag, "_tag"},   32'(retire_rob_tag), 32'(t));
    chk({tag, "_old"},   32'(commit_old_preg), 32'(old));
  endtask

  initial begin
    reset              = 1'b0;
    dispatch_valid     = 1'b0;
    dispatch_rob_tag   = '0;
    dispatch_prd       = '0;
    dispatch_old_prd   = '0;
    dispatch_rd        = '0;
    dispatch_reg_write = 1'b0;
    dispatch_is_branch = 1'b0;
    wb_valid           = 1'b0;
    wb_rob_tag         = '0;
    branch_mispredict  = 1'b0;
    mispredict_rob_tag = '0;
    #12;

    // Reset values
    chk("rst_ready", 32'(rob_ready), 1);
    chk("rst_empty", 32'(rob_empty), 1);
    chk("rst_commit_en", 32'(commit_en), 0);
    chk("rst_err", 32'(alloc_error), 0);
    chk_retire("rst", 0, 0, 0);
    chk("rst_prd", 32'(commit_prd), 0);
    chk("rst_rd", 32'(commit_rd), 0);
    reset = 1'b1;
    tick();

    // Basic in-order retire with out-of-order writeback
    disp(0, 32, 1, 1, 1, 0);
    disp(1, 33, 2, 2, 1, 0);
    disp(2, 34, 3, 3, 1, 0);
    chk("t1_noretire", 32'(retire_valid), 0);
    chk("t1_notempty", 32'(rob_empty), 0);
    wb(2);
    chk("t1_wb2_noretire", 32'(retire_valid), 0);
    wb(1);
    chk("t1_wb1_noretire", 32'(retire_valid), 0);
    wb(0);
    chk_retire("t1_r0", 1, 0, 1);
    chk("t1_r0_en", 32'(commit_en), 1);
    chk("t1_r0_prd", 32'(commit_prd), 32);
    chk("t1_r0_rd", 32'(commit_rd), 1);
    tick();
    chk_retire("t1_r1", 1, 1, 2);
    tick();
    chk_retire("t1_r2", 1, 2, 3);
    tick();
    chk("t1_empty", 32'(rob_empty), 1);
    chk("t1_idle", 32'(retire_valid), 0);

    // Fill to 16 entries starting at head=3, then overflow
    for (int i = 0; i < 16; i++) begin
      disp((3 + i) % 16, 64 + i, i, 1, 1, 0);
    end
    chk("t2_full_ready", 32'(rob_ready), 0);
    chk("t2_full_err", 32'(alloc_error), 0);
    disp(3, 100, 100, 1, 1, 0);
    chk("t2_ovf_err", 32'(alloc_error), 1);
    chk("t2_ovf_ready", 32'(rob_ready), 0);
    chk("t2_ovf_noretire", 32'(retire_valid), 0);
    wb(3);
    chk_retire("t2_r3", 1, 3, 0);
    chk("t2_r3_ready", 32'(rob_ready), 0);
    tick();
    chk("t2_after_ready", 32'(rob_ready), 1);
    chk("t2_after_idle", 32'(retire_valid), 0);
    do_reset();
    chk("t2_rst_err", 32'(alloc_error), 0);
    chk("t2_rst_empty", 32'(rob_empty), 1);

    // Advance head to 14, then retire across the wrap
    for (int i = 0; i < 14; i++) disp(i, i, i, 1, 0, 0);
    for (int i = 0; i < 14; i++) wb(i);
    tick();
    chk("t3_pre_empty", 32'(rob_empty), 1);
    disp(14, 40, 10, 2, 1, 0);
    disp(15, 41, 11, 2, 1, 0);
    disp(0, 42, 12, 2, 1, 0);
    disp(1, 43, 13, 2, 1, 0);
    chk("t3_err", 32'(alloc_error), 0);
    wb(14);
    chk_retire("t3_r14", 1, 14, 10);
    wb(15);
    chk_retire("t3_r15", 1, 15, 11);
    wb(0);
    chk_retire("t3_r0", 1, 0, 12);
    wb(1);
    chk_retire("t3_r1", 1, 1, 13);
    tick();
    chk("t3_empty", 32'(rob_empty), 1);

    // Mispredict on tag 2 with head=0; squashed writeback and dispatch dropped
    do_reset();
    for (int i = 0; i < 6; i++) disp(i, 50 + i, 20 + i, i + 1, 1, (i == 2) ? 1 : 0);
    branch_mispredict  = 1'b1;
    mispredict_rob_tag = 4'd2;
    wb_valid           = 1'b1;
    wb_rob_tag         = 4'd4;
    dispatch_valid     = 1'b1;
    dispatch_rob_tag   = 4'd6;
    tick();
    branch_mispredict  = 1'b0;
    wb_valid           = 1'b0;
    dispatch_valid     = 1'b0;
    chk("t4_ready", 32'(rob_ready), 1);
    chk("t4_err", 32'(alloc_error), 0);
    chk("t4_noretire", 32'(retire_valid), 0);
    disp(3, 60, 30, 4, 1, 0);
    chk("t4_tag3_err", 32'(alloc_error), 0);
    wb(0);
    chk_retire("t4_r0", 1, 0, 20);
    wb(1);
    chk_retire("t4_r1", 1, 1, 21);
    wb(2);
    chk_retire("t4_r2", 1, 2, 22);
    wb(3);
    chk_retire("t4_r3", 1, 3, 30);
    chk("t4_r3_prd", 32'(commit_prd), 60);
    tick();
    chk("t4_empty", 32'(rob_empty), 1);
    disp(5, 61, 31, 4, 1, 0);
    chk("t4_badtag_err", 32'(alloc_error), 1);
    chk("t4_badtag_empty", 32'(rob_empty), 1);

    // Non-writing instruction retires without commit_en
    do_reset();
    disp(0, 60, 61, 7, 0, 0);
    wb(0);
    chk("t5_valid", 32'(retire_valid), 1);
    chk("t5_en", 32'(commit_en), 0);
    chk("t5_rd", 32'(commit_rd), 7);
    chk("t5_prd", 32'(commit_prd), 60);
    tick();

    // Asynchronous reset with five entries in flight
    for (int i = 1; i < 6; i++) disp(i, 70 + i, i, i, 1, 0);
    wb(1);
    chk("t6_pre_valid", 32'(retire_valid), 1);
    chk("t6_pre_en", 32'(commit_en), 1);
    reset = 1'b0;
    #1;
    chk("t6_empty", 32'(rob_empty), 1);
    chk("t6_valid", 32'(retire_valid), 0);
    chk("t6_en", 32'(commit_en), 0);
    chk("t6_ready", 32'(rob_ready), 1);
    reset = 1'b1;
    tick();
    chk("t6_post_empty", 32'(rob_empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
